fp_mul_requester: RTL and testbench
===================================

// Module: fp_mul_requester
// PURPOSE
//  Initiator side of the team's start/done floating-point multiplier handshake.
//  Accepts operand pairs on a valid/ready stream and drives one multiplier
//  wrapper: a one-cycle start pulse, then operands held stable until done.
//  Captures the result and presents it on a valid/ready output stream.
//  Sits between the effect datapath (gain, mix, filter taps) and the FP multiplier.
// PARAMETERS
//  DATA_W          32   operand/result width (IEEE-754 single)
//  TIMEOUT_CYCLES  15   max WAIT cycles before declaring the multiplier hung
//  NAN_VALUE  32'h7FC00000  result substituted on timeout (quiet NaN)
// PORTS
//  clock       in   1       single clock domain, rising edge
//  reset_n     in   1       asynchronous, active-low reset
//  in_valid    in   1       operand pair valid
//  in_ready    out  1       requester can accept a pair (high only in IDLE)
//  in_a        in   DATA_W  operand A
//  in_b        in   DATA_W  operand B
//  mul_start   out  1       one-cycle start pulse to the multiplier (its clk_en)
//  mul_dataa   out  DATA_W  latched operand A, stable from ISSUE through WAIT
//  mul_datab   out  DATA_W  latched operand B, stable from ISSUE through WAIT
//  mul_result  in   DATA_W  multiplier result, sampled on mul_done
//  mul_done    in   1       one-cycle completion strobe from the multiplier
//  out_valid   out  1       result valid
//  out_ready   in   1       downstream accepts the result
//  out_data    out  DATA_W  captured product, or NAN_VALUE on timeout
//  out_err     out  1       qualifies out_data; 1 = timed out
//  busy        out  1       1 in any state other than IDLE
//  op_count    out  16      completed ops, both ok and err; wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, in_ready=1, mul_start=0, out_valid=0.
//   mul_dataa, mul_datab, out_data, out_err, op_count and wait_cnt all reset to 0.
//  States: IDLE -> ISSUE -> WAIT -> OUT -> IDLE.
//  IDLE
//   - in_ready=1. On in_valid && in_ready: latch in_a/in_b into mul_dataa/mul_datab.
//   - Next state ISSUE.
//  ISSUE (exactly 1 cycle)
//   - mul_start=1; operands already driven.
//   - wait_cnt<=0. Next state WAIT.
//  WAIT
//   - mul_start=0; wait_cnt increments each cycle.
//   - mul_done=1: out_data<=mul_result, out_err<=0, go to OUT.
//   - Else if wait_cnt==TIMEOUT_CYCLES-1: out_data<=NAN_VALUE, out_err<=1, go to OUT.
//   - Same-cycle mul_done and timeout: mul_done wins (out_err=0).
//  OUT
//   - out_valid=1; out_data/out_err held until out_valid && out_ready.
//   - On that transfer: op_count++ and next state IDLE.
//   - in_ready stays 0 until IDLE, so there is no same-cycle accept; max throughput is 1 op / (latency+3) clks.
//  mul_done outside WAIT (late strobe after timeout, spurious) is ignored and has no state effect.
//  mul_dataa/mul_datab change only on an IDLE accept.
//  Latency: with a responder strobing mul_done 8 clks after sampling start, out_valid rises 9 clks after the accept edge.
//  reset_n asserted mid-op: immediate return to reset values. No pending result is kept.
// TESTING
//  1. Reset: reset_n=0 for 3 clks -> in_ready=1, out_valid=0, mul_start=0, op_count=0.
//  2. Single op: a=3F800000, b=40000000, model returns 40000000 8 clks after start ->
//     out_valid 9 clks after accept; out_data=40000000; out_err=0; one mul_start pulse.
//  3. Backpressure: hold out_ready=0 for 20 clks -> out_data/out_valid stable,
//     in_ready=0 throughout; op_count increments only on release.
//  4. Timeout: model never strobes -> out_data=7FC00000, out_err=1 after 15 WAIT clks.
//     A late mul_done injected in OUT is ignored.
//  5. Race: mul_done on the timeout cycle -> out_err=0, out_data=mul_result.
//  6. Reset mid-WAIT, then 65537 back-to-back ops -> clean restart; op_count wraps to 1.

Source files
------------

// File: rtl/fp_mul_requester.sv
// Purpose: initiator for the start/done FP multiplier handshake; operand stream in, result stream out.
// Latency: out_valid rises (multiplier latency + 1) clocks after the accept edge; one op in flight, 1 op per (latency + 3) clks.
// Backpressure: in_ready is high only in IDLE; out_data/out_err are held until out_valid && out_ready.
module fp_mul_requester #(
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 15,
    parameter logic [DATA_W-1:0] NAN_VALUE      = 32'h7FC00000,
    parameter int                COUNT_W        = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    // operand stream
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_a,
    input  logic [DATA_W-1:0]  in_b,
    // multiplier wrapper
    output logic               mul_start,
    output logic [DATA_W-1:0]  mul_dataa,
    output logic [DATA_W-1:0]  mul_datab,
    input  logic [DATA_W-1:0]  mul_result,
    input  logic               mul_done,
    // result stream
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_err,
    // status
    output logic               busy,
    output logic [COUNT_W-1:0] op_count
);

    // Counter wide enough to hold 0 .. TIMEOUT_CYCLES-1 (and never zero bits wide).
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    // Single FSM: every output is a register updated alongside the state so
    // nothing combinational reaches the multiplier or the downstream stream.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            mul_start <= 1'b0;
            mul_dataa <= '0;
            mul_datab <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            busy      <= 1'b0;
            op_count  <= '0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // in_ready is always high here, so in_valid alone is the handshake.
                    if (in_valid) begin
                        mul_dataa <= in_a;
                        mul_datab <= in_b;
                        mul_start <= 1'b1;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Start pulse is exactly this one cycle; operands were latched on accept.
                    mul_start <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // A done strobe on the final wait cycle still counts as a real result.
                    if (mul_done) begin
                        out_data  <= mul_result;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= ST_OUT;
                    end else if (wait_cnt == CNT_LAST) begin
                        out_data  <= NAN_VALUE;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    // A stray done strobe here (e.g. late after timeout) is deliberately ignored.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        op_count  <= op_count + 1'b1;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    mul_start <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_requester.sv
// Directed bench for fp_mul_requester with a delay-programmable multiplier responder.
// Op counter is instantiated 8 bits wide so the wrap scenario needs 257 ops instead of 65537.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fp_mul_requester;

    localparam int DATA_W  = 32;
    localparam int COUNT_W = 8;

    logic               clock;
    logic               reset_n;
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_a;
    logic [DATA_W-1:0]  in_b;
    logic               mul_start;
    logic [DATA_W-1:0]  mul_dataa;
    logic [DATA_W-1:0]  mul_datab;
    logic [DATA_W-1:0]  mul_result;
    logic               mul_done;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic               out_err;
    logic               busy;
    logic [COUNT_W-1:0] op_count;

    int checks = 0;
    int errors = 0;

    // responder model state
    logic        resp_done;
    logic        inj_done;
    bit          resp_en;
    int          resp_delay;
    int          resp_cnt;
    int          start_pulses;
    logic [31:0] resp_result;

    assign mul_done   = resp_done | inj_done;
    assign mul_result = resp_result;

    fp_mul_requester #(
        .DATA_W        (DATA_W),
        .TIMEOUT_CYCLES(15),
        .NAN_VALUE     (32'h7FC00000),
        .COUNT_W       (COUNT_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mul_start (mul_start),
        .mul_dataa (mul_dataa),
        .mul_datab (mul_datab),
        .mul_result(mul_result),
        .mul_done  (mul_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Responder: a start seen before edge E1 produces a done strobe sampled at E1+resp_delay.
    initial begin
        resp_done    = 1'b0;
        resp_cnt     = 0;
        start_pulses = 0;
        forever begin
            @(negedge clock);
            resp_done = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt = resp_cnt - 1;
                if (resp_cnt == 0) resp_done = 1'b1;
            end
            if (mul_start === 1'b1) begin
                start_pulses = start_pulses + 1;
                if (resp_en) resp_cnt = resp_delay;
            end
        end
    end

    // Stimulus only: offer one pair, then report how many falling edges after the
    // accept edge out_valid first appears (0 = right after accept, -1 = never).
    task automatic issue_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clock);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(posedge clock);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            in_valid = 1'b0;
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start got %b want 0", mul_start); end
        checks++; if (op_count !== 8'd0) begin errors++; $display("FAIL reset_op_count got %0d want 0", op_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (out_data !== 32'h0 || out_err !== 1'b0) begin errors++; $display("FAIL reset_out got %h/%b want 0/0", out_data, out_err); end
        checks++; if (mul_dataa !== 32'h0 || mul_datab !== 32'h0) begin errors++; $display("FAIL reset_operands got %h/%h want 0/0", mul_dataa, mul_datab); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single_op();
        int lat;
        int sp0;
        resp_en     = 1'b1;
        resp_delay  = 8;
        resp_result = 32'h40000000;
        out_ready   = 1'b0;
        sp0         = start_pulses;
        issue_op(32'h3F800000, 32'h40000000, lat);
        checks++; if (lat !== 9) begin errors++; $display("FAIL single_latency got %0d want 9", lat); end
        checks++; if (out_data !== 32'h40000000) begin errors++; $display("FAIL single_data got %h want 40000000", out_data); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", out_err); end
        checks++; if (start_pulses - sp0 !== 1) begin errors++; $display("FAIL single_start_pulses got %0d want 1", start_pulses - sp0); end
        checks++; if (mul_dataa !== 32'h3F800000 || mul_datab !== 32'h40000000) begin errors++; $display("FAIL single_operands got %h/%h want 3f800000/40000000", mul_dataa, mul_datab); end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_out_flags got ready=%b busy=%b want 0/1", in_ready, busy); end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        checks++; if (op_count !== 8'd1) begin errors++; $display("FAIL single_op_count got %0d want 1", op_count); end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL single_release got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_backpressure();
        int lat;
        resp_en     = 1'b1;
        resp_delay  = 3;
        resp_result = 32'h3E800000;
        out_ready   = 1'b0;
        issue_op(32'h40400000, 32'h3F000000, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency got %0d want 4", lat); end
        // A competing pair is offered the whole time and must not be taken.
        in_valid = 1'b1;
        in_a     = 32'hDEADBEEF;
        in_b     = 32'hCAFEF00D;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h3E800000 || in_ready !== 1'b0 || op_count !== 8'd1) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got valid=%b data=%h ready=%b count=%0d want 1/3e800000/0/1",
                         i, out_valid, out_data, in_ready, op_count);
            end
        end
        in_valid = 1'b0;
        checks++; if (mul_dataa !== 32'h40400000 || mul_datab !== 32'h3F000000) begin errors++; $display("FAIL bp_operands got %h/%h want 40400000/3f000000", mul_dataa, mul_datab); end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        checks++; if (op_count !== 8'd2) begin errors++; $display("FAIL bp_release_count got %0d want 2", op_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
    endtask

    task automatic test_timeout();
        int lat;
        resp_en   = 1'b0;
        out_ready = 1'b0;
        issue_op(32'h3F800000, 32'h3F800000, lat);
        checks++; if (lat !== 16) begin errors++; $display("FAIL to_latency got %0d want 16", lat); end
        checks++; if (out_data !== 32'h7FC00000) begin errors++; $display("FAIL to_data got %h want 7fc00000", out_data); end
        checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL to_err got %b want 1", out_err); end
        // late strobe while the timeout result is waiting downstream
        inj_done = 1'b1;
        @(negedge clock);
        inj_done = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b1 || out_data !== 32'h7FC00000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL to_late_done got valid=%b err=%b data=%h busy=%b want 1/1/7fc00000/1", out_valid, out_err, out_data, busy);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        checks++; if (op_count !== 8'd3) begin errors++; $display("FAIL to_op_count got %0d want 3", op_count); end
    endtask

    task automatic test_race();
        int lat;
        resp_en     = 1'b1;
        resp_delay  = 15;
        resp_result = 32'h41200000;
        out_ready   = 1'b0;
        issue_op(32'h40A00000, 32'h40000000, lat);
        checks++; if (lat !== 16) begin errors++; $display("FAIL race_latency got %0d want 16", lat); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL race_err got %b want 0", out_err); end
        checks++; if (out_data !== 32'h41200000) begin errors++; $display("FAIL race_data got %h want 41200000", out_data); end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        checks++; if (op_count !== 8'd4) begin errors++; $display("FAIL race_op_count got %0d want 4", op_count); end
    endtask

    task automatic test_reset_mid_wait();
        resp_en = 1'b0;
        @(negedge clock);
        in_valid = 1'b1;
        in_a     = 32'h11111111;
        in_b     = 32'h22222222;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (5) @(negedge clock);
        checks++; if (busy !== 1'b1 || mul_dataa !== 32'h11111111) begin errors++; $display("FAIL rst_pre busy=%b a=%h want 1/11111111", busy, mul_dataa); end
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_flags busy=%b ready=%b want 0/1", busy, in_ready); end
        checks++; if (mul_dataa !== 32'h0 || mul_datab !== 32'h0) begin errors++; $display("FAIL rst_mid_operands got %h/%h want 0/0", mul_dataa, mul_datab); end
        checks++; if (op_count !== 8'd0 || out_valid !== 1'b0 || mul_start !== 1'b0) begin errors++; $display("FAIL rst_mid_state count=%0d valid=%b start=%b want 0/0/0", op_count, out_valid, mul_start); end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_cnt;
        int xfers;
        int cycles;
        resp_en     = 1'b1;
        resp_delay  = 1;
        resp_result = 32'h3F800000;
        out_ready   = 1'b1;
        in_a        = 32'h3F800000;
        in_b        = 32'h3F800000;
        in_valid    = 1'b1;
        exp_cnt     = 8'd0;
        xfers       = 0;
        cycles      = 0;
        while (xfers < 257 && cycles < 2000) begin
            @(negedge clock);
            cycles++;
            checks++;
            if (op_count !== exp_cnt) begin errors++; $display("FAIL b2b_count cycle %0d got %0d want %0d", cycles, op_count, exp_cnt); end
            if (out_valid === 1'b1) begin
                checks++;
                if (out_data !== 32'h3F800000 || out_err !== 1'b0) begin errors++; $display("FAIL b2b_result op %0d got %h/%b want 3f800000/0", xfers, out_data, out_err); end
                xfers++;
                exp_cnt = exp_cnt + 8'd1;
                if (xfers == 257) in_valid = 1'b0;
            end
        end
        checks++; if (xfers != 257) begin errors++; $display("FAIL b2b_xfers got %0d want 257", xfers); end
        checks++; if (cycles != 1027) begin errors++; $display("FAIL b2b_cycles got %0d want 1027", cycles); end
        @(negedge clock);
        out_ready = 1'b0;
        checks++; if (op_count !== 8'd1) begin errors++; $display("FAIL b2b_wrap got %0d want 1", op_count); end
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle ready=%b busy=%b want 1/0", in_ready, busy); end
    endtask

    initial begin
        reset_n     = 1'b1;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;
        out_ready   = 1'b0;
        inj_done    = 1'b0;
        resp_en     = 1'b0;
        resp_delay  = 0;
        resp_result = '0;
        #2;
        test_reset();
        test_single_op();
        test_backpressure();
        test_timeout();
        test_race();
        test_reset_mid_wait();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
